// File: rtl/ds_lsu_pkg.sv
// Shared constants and types for the DS-form load/store sequencer.
package ds_lsu_pkg;

    // Primary opcodes of the two DS-form groups
    localparam logic [5:0] OPC_LOAD  = 6'd58;
    localparam logic [5:0] OPC_STORE = 6'd62;

    // Extended opcode (instruction bits 30:31) values
    localparam logic [1:0] XO_0 = 2'd0;
    localparam logic [1:0] XO_1 = 2'd1;
    localparam logic [1:0] XO_2 = 2'd2;
    localparam logic [1:0] XO_3 = 2'd3;

    // Memory access size codes
    localparam logic SIZE_WORD  = 1'b0;
    localparam logic SIZE_DWORD = 1'b1;

    typedef enum logic [2:0] {
        OP_LD   = 3'd0,
        OP_LDU  = 3'd1,
        OP_LWA  = 3'd2,
        OP_STD  = 3'd3,
        OP_STDU = 3'd4,
        OP_STQ  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_REQ2  = 3'd2,
        ST_WB_RT = 3'd3,
        ST_WB_RA = 3'd4
    } state_e;

    function automatic logic op_is_load(input op_e op);
        return (op == OP_LD) || (op == OP_LDU) || (op == OP_LWA);
    endfunction

endpackage

// File: rtl/ds_lsu_sequencer_ea_calc.sv
// Effective address: optional zero base plus sign-extended, word-scaled DS immediate.
module ds_ea_calc
    import ds_lsu_pkg::*;
#(
    parameter int regWidth  = 5,
    parameter int immWidth  = 14,
    parameter int addrWidth = 64
) (
    input  logic [regWidth-1:0]  ra_sel,
    input  logic                 zero_base_en,
    input  logic [immWidth-1:0]  ds_imm,
    input  logic [addrWidth-1:0] ra_val,
    output logic [addrWidth-1:0] ea
);

    logic [addrWidth-1:0] base_s;
    logic [addrWidth-1:0] offset_s;

    // RA=0 reads as literal zero only when the form asks for it
    assign base_s   = (zero_base_en && (ra_sel == {regWidth{1'b0}})) ? {addrWidth{1'b0}} : ra_val;
    // DS field is a word offset: append two zero bits, then sign-extend
    assign offset_s = {{(addrWidth-immWidth-2){ds_imm[immWidth-1]}}, ds_imm, 2'b00};
    // Plain add, wraps modulo 2^addrWidth
    assign ea       = base_s + offset_s;

endmodule

// File: rtl/ds_lsu_sequencer.sv
// DS-form load/store sequencer: address generation, memory handshake, writeback serialisation.
module ds_lsu_sequencer
    import ds_lsu_pkg::*;
#(
    parameter int opcodeWidth = 6,
    parameter int regWidth    = 5,
    parameter int immWidth    = 14,
    parameter int dataWidth   = 64,
    parameter int addrWidth   = 64
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [opcodeWidth-1:0] opcode_i,
    input  logic [1:0]             xo_i,
    input  logic [regWidth-1:0]    reg1_i,
    input  logic [regWidth-1:0]    reg2_i,
    input  logic                   reg2ValOrZero_i,
    input  logic [immWidth-1:0]    imm_i,
    input  logic [dataWidth-1:0]   raVal_i,
    input  logic [dataWidth-1:0]   rsVal_i,
    input  logic [dataWidth-1:0]   rsPlusVal_i,
    output logic                   memReq_o,
    output logic                   memWrite_o,
    output logic                   memSize_o,
    output logic [addrWidth-1:0]   memAddr_o,
    output logic [dataWidth-1:0]   memWData_o,
    input  logic                   memAck_i,
    input  logic [dataWidth-1:0]   memRData_i,
    output logic                   wbEnable_o,
    output logic [regWidth-1:0]    wbReg_o,
    output logic [dataWidth-1:0]   wbData_o,
    output logic                   illegal_o,
    output logic                   stall_o
);

    state_e                 state_r,     state_nxt_s;
    op_e                    op_r,        op_nxt_s;
    logic [regWidth-1:0]    rt_r,        rt_nxt_s;
    logic [regWidth-1:0]    ra_r,        ra_nxt_s;
    logic [addrWidth-1:0]   ea_r,        ea_nxt_s;
    logic [dataWidth-1:0]   rs_plus_r,   rs_plus_nxt_s;
    logic                   mem_req_r,   mem_req_nxt_s;
    logic                   mem_write_r, mem_write_nxt_s;
    logic                   mem_size_r,  mem_size_nxt_s;
    logic [addrWidth-1:0]   mem_addr_r,  mem_addr_nxt_s;
    logic [dataWidth-1:0]   mem_wdata_r, mem_wdata_nxt_s;
    logic                   wb_en_r,     wb_en_nxt_s;
    logic [regWidth-1:0]    wb_reg_r,    wb_reg_nxt_s;
    logic [dataWidth-1:0]   wb_data_r,   wb_data_nxt_s;
    logic                   illegal_r,   illegal_nxt_s;
    logic                   stall_r;

    op_e                    dec_op_s;
    logic                   dec_xo_bad_s;
    logic                   dec_bad_s;
    logic [addrWidth-1:0]   ea_s;
    logic [dataWidth-1:0]   load_data_s;

    ds_ea_calc #(
        .regWidth (regWidth),
        .immWidth (immWidth),
        .addrWidth(addrWidth)
    ) u_ea_calc (
        .ra_sel      (reg2_i),
        .zero_base_en(reg2ValOrZero_i),
        .ds_imm      (imm_i),
        .ra_val      (raVal_i),
        .ea          (ea_s)
    );

    // Map opcode/xo onto an operation; unknown opcodes and xo=3 are invalid
    always_comb begin
        dec_op_s     = OP_LD;
        dec_xo_bad_s = 1'b0;
        if (opcode_i == OPC_LOAD) begin
            case (xo_i)
                XO_0:    dec_op_s = OP_LD;
                XO_1:    dec_op_s = OP_LDU;
                XO_2:    dec_op_s = OP_LWA;
                default: dec_xo_bad_s = 1'b1;
            endcase
        end else if (opcode_i == OPC_STORE) begin
            case (xo_i)
                XO_0:    dec_op_s = OP_STD;
                XO_1:    dec_op_s = OP_STDU;
                XO_2:    dec_op_s = OP_STQ;
                default: dec_xo_bad_s = 1'b1;
            endcase
        end else begin
            dec_xo_bad_s = 1'b1;
        end
    end

    // Update forms need a real RA; ldu may not overwrite its own base; stq needs an even pair
    assign dec_bad_s = dec_xo_bad_s
                     || (((dec_op_s == OP_LDU) || (dec_op_s == OP_STDU)) && (reg2_i == {regWidth{1'b0}}))
                     || ((dec_op_s == OP_LDU) && (reg2_i == reg1_i))
                     || ((dec_op_s == OP_STQ) && reg1_i[0]);

    // lwa returns the low word sign-extended; doubleword loads pass through
    assign load_data_s = (op_r == OP_LWA) ? {{(dataWidth-32){memRData_i[31]}}, memRData_i[31:0]}
                                          : memRData_i;

    // Next-state and next-output logic; everything holds unless a transition says otherwise
    always_comb begin
        state_nxt_s     = state_r;
        op_nxt_s        = op_r;
        rt_nxt_s        = rt_r;
        ra_nxt_s        = ra_r;
        ea_nxt_s        = ea_r;
        rs_plus_nxt_s   = rs_plus_r;
        mem_req_nxt_s   = mem_req_r;
        mem_write_nxt_s = mem_write_r;
        mem_size_nxt_s  = mem_size_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        wb_en_nxt_s     = 1'b0;
        wb_reg_nxt_s    = wb_reg_r;
        wb_data_nxt_s   = wb_data_r;
        illegal_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_i && dec_bad_s) begin
                    illegal_nxt_s = 1'b1;
                end else if (enable_i) begin
                    state_nxt_s     = ST_REQ;
                    op_nxt_s        = dec_op_s;
                    rt_nxt_s        = reg1_i;
                    ra_nxt_s        = reg2_i;
                    ea_nxt_s        = ea_s;
                    rs_plus_nxt_s   = rsPlusVal_i;
                    mem_req_nxt_s   = 1'b1;
                    mem_write_nxt_s = !op_is_load(dec_op_s);
                    mem_size_nxt_s  = (dec_op_s == OP_LWA) ? SIZE_WORD : SIZE_DWORD;
                    mem_addr_nxt_s  = ea_s;
                    mem_wdata_nxt_s = op_is_load(dec_op_s) ? {dataWidth{1'b0}} : rsVal_i;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (memAck_i && (op_r == OP_STQ)) begin
                    // Second beat goes out back-to-back with the next doubleword
                    state_nxt_s     = ST_REQ2;
                    mem_addr_nxt_s  = ea_r + {{(addrWidth-4){1'b0}}, 4'd8};
                    mem_wdata_nxt_s = rs_plus_r;
                end else if (memAck_i && op_is_load(op_r)) begin
                    state_nxt_s   = ST_WB_RT;
                    mem_req_nxt_s = 1'b0;
                    wb_en_nxt_s   = 1'b1;
                    wb_reg_nxt_s  = rt_r;
                    wb_data_nxt_s = load_data_s;
                end else if (memAck_i && (op_r == OP_STDU)) begin
                    state_nxt_s   = ST_WB_RA;
                    mem_req_nxt_s = 1'b0;
                    wb_en_nxt_s   = 1'b1;
                    wb_reg_nxt_s  = ra_r;
                    wb_data_nxt_s = ea_r;
                end else if (memAck_i) begin
                    state_nxt_s   = ST_IDLE;
                    mem_req_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REQ2: begin
                if (memAck_i) begin
                    state_nxt_s   = ST_IDLE;
                    mem_req_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_REQ2;
                end
            end
            ST_WB_RT: begin
                if (op_r == OP_LDU) begin
                    state_nxt_s   = ST_WB_RA;
                    wb_en_nxt_s   = 1'b1;
                    wb_reg_nxt_s  = ra_r;
                    wb_data_nxt_s = ea_r;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB_RA: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                mem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched operands and all outputs are flops cleared by the async reset
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_LD;
            rt_r        <= {regWidth{1'b0}};
            ra_r        <= {regWidth{1'b0}};
            ea_r        <= {addrWidth{1'b0}};
            rs_plus_r   <= {dataWidth{1'b0}};
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            mem_size_r  <= 1'b0;
            mem_addr_r  <= {addrWidth{1'b0}};
            mem_wdata_r <= {dataWidth{1'b0}};
            wb_en_r     <= 1'b0;
            wb_reg_r    <= {regWidth{1'b0}};
            wb_data_r   <= {dataWidth{1'b0}};
            illegal_r   <= 1'b0;
            stall_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            op_r        <= op_nxt_s;
            rt_r        <= rt_nxt_s;
            ra_r        <= ra_nxt_s;
            ea_r        <= ea_nxt_s;
            rs_plus_r   <= rs_plus_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_write_r <= mem_write_nxt_s;
            mem_size_r  <= mem_size_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            wb_en_r     <= wb_en_nxt_s;
            wb_reg_r    <= wb_reg_nxt_s;
            wb_data_r   <= wb_data_nxt_s;
            illegal_r   <= illegal_nxt_s;
            stall_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign memReq_o   = mem_req_r;
    assign memWrite_o = mem_write_r;
    assign memSize_o  = mem_size_r;
    assign memAddr_o  = mem_addr_r;
    assign memWData_o = mem_wdata_r;
    assign wbEnable_o = wb_en_r;
    assign wbReg_o    = wb_reg_r;
    assign wbData_o   = wb_data_r;
    assign illegal_o  = illegal_r;
    assign stall_o    = stall_r;

endmodule

// File: tb/tb_ds_lsu_sequencer.sv
// Self-checking bench for ds_lsu_sequencer: directed table, corner sequences, random ops vs. model.
module tb_ds_lsu_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [5:0]  opcode_i = 6'd0;
    logic [1:0]  xo_i = 2'd0;
    logic [4:0]  reg1_i = 5'd0;
    logic [4:0]  reg2_i = 5'd0;
    logic        reg2ValOrZero_i = 1'b0;
    logic [13:0] imm_i = 14'd0;
    logic [63:0] raVal_i = 64'd0;
    logic [63:0] rsVal_i = 64'd0;
    logic [63:0] rsPlusVal_i = 64'd0;
    logic        memAck_i = 1'b0;
    logic [63:0] memRData_i = 64'd0;
    logic        memReq_o, memWrite_o, memSize_o, wbEnable_o, illegal_o, stall_o;
    logic [63:0] memAddr_o, memWData_o, wbData_o;
    logic [4:0]  wbReg_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock_i = ~clock_i;

    ds_lsu_sequencer dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .opcode_i(opcode_i),
        .xo_i(xo_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .reg2ValOrZero_i(reg2ValOrZero_i),
        .imm_i(imm_i), .raVal_i(raVal_i), .rsVal_i(rsVal_i), .rsPlusVal_i(rsPlusVal_i),
        .memReq_o(memReq_o), .memWrite_o(memWrite_o), .memSize_o(memSize_o),
        .memAddr_o(memAddr_o), .memWData_o(memWData_o), .memAck_i(memAck_i),
        .memRData_i(memRData_i), .wbEnable_o(wbEnable_o), .wbReg_o(wbReg_o),
        .wbData_o(wbData_o), .illegal_o(illegal_o), .stall_o(stall_o)
    );

    // Inputs, ack delay, then the expected columns: illegal, first address, size, RT data
    typedef struct {
        logic [5:0]  opc;
        logic [1:0]  xo;
        logic [4:0]  rt;
        logic [4:0]  ra;
        logic        rvz;
        logic [13:0] imm;
        logic [63:0] raval;
        logic [63:0] rsval;
        logic [63:0] rsplus;
        logic [63:0] rdata;
        int          dly;
        logic        x_ill;
        logic [63:0] x_addr;
        logic        x_size;
        logic [63:0] x_rtdata;
    } vec_t;

    // Full expected transaction: memory beats then writebacks in order
    typedef struct {
        logic             illegal;
        int               nbeats;
        logic             write;
        logic             size;
        logic [1:0][63:0] addr;
        logic [1:0][63:0] wdata;
        int               nwb;
        logic [1:0][4:0]  wreg;
        logic [1:0][63:0] wdat;
    } exp_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expand the expected columns into the beat/writeback sequence the op implies
    function automatic exp_t expand(input vec_t v);
        exp_t e;
        e.illegal = v.x_ill; e.nbeats = 0; e.write = 1'b0; e.size = v.x_size;
        e.addr = '0; e.wdata = '0; e.nwb = 0; e.wreg = '0; e.wdat = '0;
        if (!v.x_ill) begin
            e.nbeats = 1;
            e.addr[0] = v.x_addr;
            if (v.opc == 6'd58) begin
                e.nwb = 1; e.wreg[0] = v.rt; e.wdat[0] = v.x_rtdata;
                if (v.xo == 2'd1) begin
                    e.nwb = 2; e.wreg[1] = v.ra; e.wdat[1] = v.x_addr;
                end
            end else begin
                e.write = 1'b1; e.wdata[0] = v.rsval;
                if (v.xo == 2'd1) begin
                    e.nwb = 1; e.wreg[0] = v.ra; e.wdat[0] = v.x_addr;
                end else if (v.xo == 2'd2) begin
                    e.nbeats = 2; e.addr[1] = v.x_addr + 64'd8; e.wdata[1] = v.rsplus;
                end
            end
        end
        return e;
    endfunction

    // Reference model: derive expected columns from the instruction-set rules
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        logic   is_ld, is_st, upd;
        int     s;
        longint w;
        logic [63:0] base;
        r = v;
        is_ld = (v.opc == 6'd58);
        is_st = (v.opc == 6'd62);
        upd   = (v.xo == 2'd1);
        r.x_ill = !(is_ld || is_st) || (v.xo == 2'd3) || (upd && v.ra == 5'd0)
                  || (is_ld && upd && v.ra == v.rt) || (is_st && v.xo == 2'd2 && v.rt[0]);
        s = (v.imm >= 14'd8192) ? int'(v.imm) - 16384 : int'(v.imm);
        base = (v.rvz && v.ra == 5'd0) ? 64'd0 : v.raval;
        r.x_addr = base + 64'(longint'(s) * 64'sd4);
        r.x_size = !(is_ld && v.xo == 2'd2);
        w = longint'(v.rdata[31:0]);
        if (w >= 64'sh80000000) w = w - 64'sh100000000;
        r.x_rtdata = (is_ld && v.xo == 2'd2) ? 64'(w) : v.rdata;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        opcode_i = v.opc; xo_i = v.xo; reg1_i = v.rt; reg2_i = v.ra;
        reg2ValOrZero_i = v.rvz; imm_i = v.imm; raVal_i = v.raval;
        rsVal_i = v.rsval; rsPlusVal_i = v.rsplus; memRData_i = v.rdata;
    endtask

    // One op from an idle sequencer: issue, serve each beat after dly cycles, check writebacks
    task automatic run_op(input string nm, input vec_t v, input exp_t e);
        @(negedge clock_i);
        drive(v);
        enable_i = 1'b1;
        @(negedge clock_i);
        enable_i = 1'b0;
        if (e.illegal) begin
            chk({nm, ".illegal"}, 64'(illegal_o), 64'd1);
            chk({nm, ".ill_req"}, 64'(memReq_o), 64'd0);
            chk({nm, ".ill_stall"}, 64'(stall_o), 64'd0);
            @(negedge clock_i);
            chk({nm, ".ill_pulse"}, 64'(illegal_o), 64'd0);
            chk({nm, ".ill_wb"}, 64'(wbEnable_o), 64'd0);
            return;
        end
        for (int b = 0; b < e.nbeats; b++) begin
            for (int c = 0; c <= v.dly; c++) begin
                chk({nm, ".req"}, 64'(memReq_o), 64'd1);
                chk({nm, ".addr"}, memAddr_o, e.addr[b]);
                chk({nm, ".write"}, 64'(memWrite_o), 64'(e.write));
                chk({nm, ".size"}, 64'(memSize_o), 64'(e.size));
                if (e.write) chk({nm, ".wdata"}, memWData_o, e.wdata[b]);
                chk({nm, ".busy"}, 64'(stall_o), 64'd1);
                chk({nm, ".no_wb"}, 64'(wbEnable_o), 64'd0);
                if (c == v.dly) memAck_i = 1'b1;
                @(negedge clock_i);
                memAck_i = 1'b0;
            end
        end
        for (int k = 0; k < e.nwb; k++) begin
            chk({nm, ".wb_en"}, 64'(wbEnable_o), 64'd1);
            chk({nm, ".wb_reg"}, 64'(wbReg_o), 64'(e.wreg[k]));
            chk({nm, ".wb_data"}, wbData_o, e.wdat[k]);
            chk({nm, ".wb_busy"}, 64'(stall_o), 64'd1);
            chk({nm, ".wb_req"}, 64'(memReq_o), 64'd0);
            @(negedge clock_i);
        end
        chk({nm, ".done_stall"}, 64'(stall_o), 64'd0);
        chk({nm, ".done_req"}, 64'(memReq_o), 64'd0);
        chk({nm, ".done_wb"}, 64'(wbEnable_o), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".req"}, 64'(memReq_o), 64'd0);
        chk({nm, ".write"}, 64'(memWrite_o), 64'd0);
        chk({nm, ".size"}, 64'(memSize_o), 64'd0);
        chk({nm, ".addr"}, memAddr_o, 64'd0);
        chk({nm, ".wdata"}, memWData_o, 64'd0);
        chk({nm, ".wb_en"}, 64'(wbEnable_o), 64'd0);
        chk({nm, ".wb_reg"}, 64'(wbReg_o), 64'd0);
        chk({nm, ".wb_data"}, wbData_o, 64'd0);
        chk({nm, ".illegal"}, 64'(illegal_o), 64'd0);
        chk({nm, ".stall"}, 64'(stall_o), 64'd0);
    endtask

    // Bound the run even if the sequencing above goes astray
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //         opc    xo    rt    ra    rvz   imm       raval                  rsval                  rsplus                 rdata                  dly  ill   addr                   size  rtdata
        tbl[0]  = '{6'd58, 2'd0, 5'd5, 5'd0, 1'b1, 14'h0004, 64'h777,               64'h0,                 64'h0,                 64'hDEADBEEF_00000001, 0, 1'b0, 64'h10,                1'b1, 64'hDEADBEEF_00000001};
        tbl[1]  = '{6'd58, 2'd2, 5'd7, 5'd1, 1'b1, 14'h3FFF, 64'h1000,              64'h0,                 64'h0,                 64'h12345678_80000000, 1, 1'b0, 64'hFFC,               1'b0, 64'hFFFFFFFF_80000000};
        tbl[2]  = '{6'd58, 2'd1, 5'd3, 5'd4, 1'b0, 14'h0002, 64'h2000,              64'h0,                 64'h0,                 64'h01234567_89ABCDEF, 3, 1'b0, 64'h2008,              1'b1, 64'h01234567_89ABCDEF};
        tbl[3]  = '{6'd62, 2'd2, 5'd6, 5'd2, 1'b0, 14'h0000, 64'h100,               64'hA0A0A0A0_11111111, 64'hB0B0B0B0_22222222, 64'h0,                 1, 1'b0, 64'h100,               1'b1, 64'h0};
        tbl[4]  = '{6'd62, 2'd2, 5'd7, 5'd2, 1'b0, 14'h0000, 64'h100,               64'hA0A0A0A0_11111111, 64'hB0B0B0B0_22222222, 64'h0,                 0, 1'b1, 64'h0,                 1'b1, 64'h0};
        tbl[5]  = '{6'd62, 2'd1, 5'd4, 5'd0, 1'b1, 14'h0005, 64'h300,               64'h55,                64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 1'b1, 64'h0};
        tbl[6]  = '{6'd58, 2'd3, 5'd1, 5'd2, 1'b0, 14'h0000, 64'h400,               64'h0,                 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 1'b1, 64'h0};
        tbl[7]  = '{6'd62, 2'd0, 5'd9, 5'd10, 1'b0, 14'h2000, 64'h4000,             64'hCAFEF00D_12345678, 64'h0,                 64'h0,                 2, 1'b0, 64'hFFFFFFFF_FFFFC000, 1'b1, 64'h0};
        tbl[8]  = '{6'd62, 2'd1, 5'd1, 5'd31, 1'b0, 14'h0001, 64'h8,                64'h0F0F0F0F_0F0F0F0F, 64'h0,                 64'h0,                 0, 1'b0, 64'hC,                 1'b1, 64'h0};
        tbl[9]  = '{6'd58, 2'd1, 5'd3, 5'd3, 1'b0, 14'h0001, 64'h8,                 64'h0,                 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 1'b1, 64'h0};
        tbl[10] = '{6'd58, 2'd0, 5'd12, 5'd0, 1'b0, 14'h0000, 64'h50,               64'h0,                 64'h0,                 64'h5555AAAA_5555AAAA, 1, 1'b0, 64'h50,                1'b1, 64'h5555AAAA_5555AAAA};
        tbl[11] = '{6'd58, 2'd0, 5'd13, 5'd14, 1'b1, 14'h0004, 64'hFFFFFFFF_FFFFFFF8, 64'h0,                64'h0,                 64'h1,                 0, 1'b0, 64'h8,                 1'b1, 64'h1};
        tbl[12] = '{6'd58, 2'd1, 5'd3, 5'd0, 1'b1, 14'h0001, 64'h8,                 64'h0,                 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 1'b1, 64'h0};

        // Reset state
        repeat (2) @(negedge clock_i);
        chk_all_zero("reset");
        reset_i = 1'b0;

        // Directed table
        for (int i = 0; i < 13; i++) run_op($sformatf("tbl%0d", i), tbl[i], expand(tbl[i]));

        // enable_i held through a busy op: the second op waits for stall_o to drop
        v = tbl[10];
        v.opc = 6'd58; v.xo = 2'd0; v.rt = 5'd1; v.ra = 5'd2; v.rvz = 1'b0; v.imm = 14'd1;
        v.raval = 64'h500; v.rdata = 64'h77;
        @(negedge clock_i);
        drive(v);
        enable_i = 1'b1;
        @(negedge clock_i);
        chk("busy.req", 64'(memReq_o), 64'd1);
        chk("busy.addr", memAddr_o, 64'h504);
        opcode_i = 6'd62; reg1_i = 5'd8; raVal_i = 64'h900; imm_i = 14'd0; rsVal_i = 64'h1234;
        @(negedge clock_i);
        chk("busy.hold_addr", memAddr_o, 64'h504);
        chk("busy.hold_write", 64'(memWrite_o), 64'd0);
        memAck_i = 1'b1;
        @(negedge clock_i);
        memAck_i = 1'b0;
        chk("busy.wb_en", 64'(wbEnable_o), 64'd1);
        chk("busy.wb_reg", 64'(wbReg_o), 64'd1);
        chk("busy.wb_data", wbData_o, 64'h77);
        chk("busy.stall", 64'(stall_o), 64'd1);
        @(negedge clock_i);
        chk("busy.idle", 64'(stall_o), 64'd0);
        chk("busy.no_req", 64'(memReq_o), 64'd0);
        @(negedge clock_i);
        enable_i = 1'b0;
        chk("busy.second_req", 64'(memReq_o), 64'd1);
        chk("busy.second_addr", memAddr_o, 64'h900);
        chk("busy.second_write", 64'(memWrite_o), 64'd1);
        chk("busy.second_wdata", memWData_o, 64'h1234);
        memAck_i = 1'b1;
        @(negedge clock_i);
        memAck_i = 1'b0;
        chk("busy.second_done", 64'(stall_o), 64'd0);
        chk("busy.second_req_off", 64'(memReq_o), 64'd0);

        // Reset while a request is outstanding, then a late ack
        v = tbl[0];
        v.imm = 14'd8;
        @(negedge clock_i);
        drive(v);
        enable_i = 1'b1;
        @(negedge clock_i);
        enable_i = 1'b0;
        chk("rst.req_before", 64'(memReq_o), 64'd1);
        chk("rst.addr_before", memAddr_o, 64'h20);
        reset_i = 1'b1;
        #1;
        chk_all_zero("rst.async");
        @(negedge clock_i);
        reset_i = 1'b0;
        memAck_i = 1'b1;
        @(negedge clock_i);
        memAck_i = 1'b0;
        chk("rst.late_req", 64'(memReq_o), 64'd0);
        chk("rst.late_stall", 64'(stall_o), 64'd0);
        chk("rst.late_wb", 64'(wbEnable_o), 64'd0);
        @(negedge clock_i);
        chk("rst.late_wb2", 64'(wbEnable_o), 64'd0);
        run_op("rst.next_ld", tbl[0], expand(tbl[0]));

        // Random ops checked against the model
        for (int i = 0; i < 60; i++) begin
            v.opc    = ($urandom_range(0, 1) == 0) ? 6'd58 : 6'd62;
            v.xo     = 2'($urandom_range(0, 3));
            v.rt     = 5'($urandom_range(0, 31));
            v.ra     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            v.rvz    = 1'($urandom_range(0, 1));
            v.imm    = 14'($urandom);
            v.raval  = {$urandom, $urandom};
            v.rsval  = {$urandom, $urandom};
            v.rsplus = {$urandom, $urandom};
            v.rdata  = {$urandom, $urandom};
            v.dly    = int'($urandom_range(0, 3));
            v = model(v);
            run_op($sformatf("rnd%0d", i), v, expand(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
